// File: rtl/keypad_pkg.sv
// Shared types, key map and small combinational helpers for the keypad
// scanner and its neighbours.
package keypad_pkg;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_t;

  localparam logic [3:0] ROW_INIT = 4'b1110;

  // Indexed [row][col]; star reads as E, hash as F.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] lowest_low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when two or more lines are low: clearing the lowest set bit of
  // the inverted vector leaves something behind.
  function automatic logic multi_low(input logic [3:0] c);
    logic [3:0] z;
    z = ~c;
    return (z & (z - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs handed to the debouncer.
interface keypad_scanner_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       multi_key;

  modport master (input cols, output rows, output key_code, output key_pressed, output multi_key);
  modport slave  (output cols, input rows, input key_code, input key_pressed, input multi_key);
endinterface

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for asynchronous inputs, with a
// configurable reset value.
module sync_ff #(
  parameter int                WIDTH     = 1,
  parameter int                STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // shift chain; stage 0 is the only flop that sees the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_r[i] <= RESET_VAL;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row, samples synchronized
// columns once per dwell and holds the detected key until its column opens.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 48000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  scan_state_t      state_r, state_n;
  logic [1:0]       row_idx_r, row_idx_n;
  logic [DIV_W-1:0] div_r, div_n;
  logic [1:0]       held_col_r, held_col_n;
  logic [3:0]       key_code_r, key_code_n;
  logic             multi_key_r, multi_key_n;
  logic             key_pressed_r;
  logic [3:0]       rows_r;
  logic [3:0]       cols_s;
  logic             sample_s;
  logic [1:0]       low_col_s;

  sync_ff #(
    .WIDTH    (4),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(4'b1111)
  ) u_col_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (kp.cols),
    .q    (cols_s)
  );

  assign sample_s  = (div_r == DIV_W'(SCAN_DIV - 1));
  assign low_col_s = lowest_low_col(cols_s);

  // state and datapath registers; rows and status flags follow next-state values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= SCAN;
      row_idx_r     <= 2'd0;
      div_r         <= {DIV_W{1'b0}};
      held_col_r    <= 2'd0;
      key_code_r    <= 4'h0;
      multi_key_r   <= 1'b0;
      key_pressed_r <= 1'b0;
      rows_r        <= ROW_INIT;
    end else begin
      state_r       <= state_n;
      row_idx_r     <= row_idx_n;
      div_r         <= div_n;
      held_col_r    <= held_col_n;
      key_code_r    <= key_code_n;
      multi_key_r   <= multi_key_n;
      key_pressed_r <= (state_n == HOLD);
      rows_r        <= row_drive(row_idx_n);
    end
  end

  // next state: a low column at the dwell sample enters HOLD, the held column opening leaves it
  always_comb begin
    state_n = state_r;
    case (state_r)
      SCAN: begin
        if (sample_s && (cols_s != 4'b1111)) state_n = HOLD;
        else                                 state_n = SCAN;
      end
      HOLD: begin
        if (cols_s[held_col_r]) state_n = SCAN;
        else                    state_n = HOLD;
      end
      default: state_n = SCAN;
    endcase
  end

  // datapath next values: divider, row index and latched key information
  always_comb begin
    row_idx_n   = row_idx_r;
    div_n       = div_r;
    held_col_n  = held_col_r;
    key_code_n  = key_code_r;
    multi_key_n = multi_key_r;
    case (state_r)
      SCAN: begin
        multi_key_n = 1'b0;
        if (!sample_s) begin
          div_n = div_r + DIV_W'(1);
        end else begin
          div_n = {DIV_W{1'b0}};
          if (cols_s == 4'b1111) begin
            row_idx_n = row_idx_r + 2'd1;
          end else begin
            held_col_n  = low_col_s;
            key_code_n  = KEYMAP[row_idx_r][low_col_s];
            multi_key_n = multi_low(cols_s);
          end
        end
      end
      HOLD: begin
        div_n = {DIV_W{1'b0}};
        if (cols_s[held_col_r]) begin
          row_idx_n   = row_idx_r + 2'd1;
          multi_key_n = 1'b0;
        end else begin
          multi_key_n = multi_key_r;
        end
      end
      default: begin
        row_idx_n   = 2'd0;
        div_n       = {DIV_W{1'b0}};
        multi_key_n = 1'b0;
      end
    endcase
  end

  assign kp.rows        = rows_r;
  assign kp.key_code    = key_code_r;
  assign kp.key_pressed = key_pressed_r;
  assign kp.multi_key   = multi_key_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a physical keypad model drives the columns and a
// behavioural scan model predicts rows/key outputs every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int SS       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [63:0] keys = 64'h123A_456B_789C_E0FD;
  int          checks = 0;
  int          errors = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .SYNC_STAGES(SS)) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  // pressed[row*4+col] shorts that row to that column
  function automatic logic [3:0] phys_cols(input logic [3:0] r, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!r[i] && p[i*4+j]) c[j] = 1'b0;
    return c;
  endfunction

  function automatic logic [3:0] row_vec(input int r);
    logic [3:0] v;
    v = 4'hF;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  int          m_row, m_dwell, m_col;
  bit          m_hold, m_multi;
  logic [3:0]  m_code;
  logic [3:0]  m_hist [SS];

  always @(posedge clk or negedge reset) begin : model
    logic [3:0] seen;
    int nrow, ndwell, ncol, zeros;
    bit nhold, nmulti;
    logic [3:0] ncode;
    if (!reset) begin
      m_row <= 0; m_dwell <= 0; m_col <= 0;
      m_hold <= 1'b0; m_multi <= 1'b0; m_code <= 4'h0;
      for (int i = 0; i < SS; i++) m_hist[i] <= 4'hF;
    end else begin
      seen = m_hist[SS-1];
      nrow = m_row; ndwell = m_dwell; ncol = m_col;
      nhold = m_hold; nmulti = m_multi; ncode = m_code;
      if (!m_hold) begin
        nmulti = 1'b0;
        if (m_dwell == SCAN_DIV - 1) begin
          ndwell = 0;
          if (seen == 4'hF) begin
            nrow = (m_row + 1) % 4;
          end else begin
            zeros = 0; ncol = -1;
            for (int j = 0; j < 4; j++)
              if (!seen[j]) begin
                zeros++;
                if (ncol < 0) ncol = j;
              end
            nhold  = 1'b1;
            ncode  = keys[63 - 4*(m_row*4 + ncol) -: 4];
            nmulti = (zeros > 1);
          end
        end else begin
          ndwell = m_dwell + 1;
        end
      end else if (seen[m_col]) begin
        nhold  = 1'b0;
        nrow   = (m_row + 1) % 4;
        nmulti = 1'b0;
      end
      for (int i = SS - 1; i > 0; i--) m_hist[i] <= m_hist[i-1];
      m_hist[0] <= phys_cols(row_vec(m_row), pressed);
      m_row <= nrow; m_dwell <= ndwell; m_col <= ncol;
      m_hold <= nhold; m_multi <= nmulti; m_code <= ncode;
    end
  end

  assign kif.cols = phys_cols(kif.rows, pressed);

  always @(negedge clk) begin : compare
    check("rows", kif.rows, row_vec(m_row));
    check("key_pressed", kif.key_pressed, m_hold);
    check("key_code", kif.key_code, m_code);
    check("multi_key", kif.multi_key, m_multi);
  end

  task automatic wait_level(input string name, input logic lvl, input int budget);
    int n;
    n = 0;
    while (kif.key_pressed !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, kif.key_pressed, lvl);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset_rows", kif.rows, 4'b1110);
    check("reset_pressed", kif.key_pressed, 1'b0);
    check("reset_code", kif.key_code, 4'h0);
    check("reset_multi", kif.multi_key, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 7)  check("scan_r0_end", kif.rows, 4'b1110);
      if (k == 8)  check("scan_r1", kif.rows, 4'b1101);
      if (k == 16) check("scan_r2", kif.rows, 4'b1011);
      if (k == 24) check("scan_r3", kif.rows, 4'b0111);
      if (k == 32) check("scan_wrap", kif.rows, 4'b1110);
    end
    check("idle_pressed", kif.key_pressed, 1'b0);

    // key 5
    pressed = 16'h0020;
    wait_level("key5_latency", 1'b1, 35);
    check("key5_code", kif.key_code, 4'h5);
    check("key5_multi", kif.multi_key, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k % 25 == 0) check("key5_rows_frozen", kif.rows, 4'b1101);
    end
    pressed = 16'h0000;
    wait_level("key5_release", 1'b0, SS + 1);
    check("key5_code_held", kif.key_code, 4'h5);
    check("key5_next_row", kif.rows, 4'b1011);
    settle();

    // star then hash
    pressed = 16'h1000;
    wait_level("star_press", 1'b1, 36);
    check("star_code", kif.key_code, 4'hE);
    pressed = 16'h0000;
    wait_level("star_release", 1'b0, SS + 1);
    settle();
    pressed = 16'h4000;
    wait_level("hash_press", 1'b1, 36);
    check("hash_code", kif.key_code, 4'hF);
    pressed = 16'h0000;
    wait_level("hash_release", 1'b0, SS + 1);
    settle();

    // B and 6 together, then drop 6 only
    pressed = 16'h00C0;
    wait_level("b6_press", 1'b1, 36);
    check("b6_code", kif.key_code, 4'h6);
    check("b6_multi", kif.multi_key, 1'b1);
    repeat (10) @(negedge clk);
    pressed = 16'h0080;
    wait_level("b6_release_col2", 1'b0, SS + 1);
    check("b6_multi_clear", kif.multi_key, 1'b0);
    repeat (40) @(negedge clk);
    pressed = 16'h0000;
    wait_level("b_release", 1'b0, 40);
    settle();

    // reset while holding key 9
    pressed = 16'h0400;
    wait_level("key9_press", 1'b1, 36);
    check("key9_code", kif.key_code, 4'h9);
    reset = 1'b0;
    #1;
    check("rst_async_pressed", kif.key_pressed, 1'b0);
    check("rst_async_code", kif.key_code, 4'h0);
    check("rst_async_rows", kif.rows, 4'b1110);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_level("key9_redetect", 1'b1, 36);
    check("key9_recode", kif.key_code, 4'h9);
    pressed = 16'h0000;
    wait_level("key9_release", 1'b0, SS + 1);
    settle();

    // random single and double presses, including very short ones
    for (int t = 0; t < 40; t++) begin
      logic [15:0] p;
      p = 16'h0000;
      p[$urandom_range(15, 0)] = 1'b1;
      if ($urandom_range(3, 0) == 0) p[$urandom_range(15, 0)] = 1'b1;
      pressed = p;
      repeat ($urandom_range(80, 1)) @(negedge clk);
      pressed = 16'h0000;
      repeat ($urandom_range(40, 1)) @(negedge clk);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
